// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/pause/game-over sequencing, scoring and per-frame step strobes.
// Optional speed ramp on paddle hits is enabled by defining PONG_SPEED_RAMP_EN.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned STEPS_BASE   = 4,
    parameter int unsigned STEP_GAP     = 256,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_start,
    input  logic       i_key_serve_n,
    input  logic       i_ball_out_left,
    input  logic       i_ball_out_right,
    input  logic       i_paddle_hit,
    output logic       o_move_stb,
    output logic       o_ball_recenter,
    output logic       o_serve_dir,
    output logic [3:0] o_score_p1,
    output logic [3:0] o_score_p2,
    output logic       o_game_over,
    output logic [2:0] o_state
);

    localparam int unsigned GapW = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StServeWait  = 3'd1,
        StPlay       = 3'd2,
        StPointPause = 3'd3,
        StGameOver   = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_key_s1, r_key_s2, r_key_s3, r_press;
    logic              r_move_stb, r_ball_recenter, r_serve_dir, r_game_over;
    logic [3:0]        r_score_p1, r_score_p2;
    logic [3:0]        r_steps;
    logic [GapW-1:0]   r_gap;
    logic [7:0]        r_pause;
    logic [1:0]        w_speed;
    logic [3:0]        w_steps_load;
    logic              w_point;

    assign w_point      = i_ball_out_left | i_ball_out_right;
    assign w_steps_load = 4'(STEPS_BASE) + {2'b00, w_speed};

    // Two-flop synchroniser, then a registered falling-edge detect.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_key_s3 <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_key_s1 <= i_key_serve_n;
            r_key_s2 <= r_key_s1;
            r_key_s3 <= r_key_s2;
            r_press  <= r_key_s3 & ~r_key_s2;
        end
    end

`ifdef PONG_SPEED_RAMP_EN
    logic [1:0] r_speed, r_hit_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_speed   <= 2'd0;
            r_hit_cnt <= 2'd0;
        end else if (r_state == StPlay) begin
            if (w_point) begin
                r_speed   <= 2'd0;
                r_hit_cnt <= 2'd0;
            end else if (i_paddle_hit) begin
                r_hit_cnt <= r_hit_cnt + 2'd1;
                if (r_hit_cnt == 2'd3 && r_speed != 2'd3) r_speed <= r_speed + 2'd1;
            end
        end
    end

    assign w_speed = r_speed;
`else
    logic w_unused_hit;
    assign w_unused_hit = i_paddle_hit;
    assign w_speed      = 2'd0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_score_p1      <= 4'd0;
            r_score_p2      <= 4'd0;
            r_serve_dir     <= 1'b1;
            r_move_stb      <= 1'b0;
            r_ball_recenter <= 1'b0;
            r_game_over     <= 1'b0;
            r_steps         <= 4'd0;
            r_gap           <= '0;
            r_pause         <= 8'd0;
        end else begin
            r_move_stb      <= 1'b0;
            r_ball_recenter <= 1'b0;
            unique case (r_state)
                StIdle: if (r_press) begin
                    r_state         <= StServeWait;
                    r_ball_recenter <= 1'b1;
                end
                StServeWait: if (r_press) begin
                    r_state <= StPlay;
                    r_steps <= 4'd0;
                end
                StPlay: begin
                    if (w_point) begin
                        // A point wins over a coincident frame_start and kills pending steps.
                        r_ball_recenter <= 1'b1;
                        r_steps         <= 4'd0;
                        r_pause         <= 8'd0;
                        r_state         <= StPointPause;
                        if (i_ball_out_left && !i_ball_out_right) begin
                            r_score_p2  <= r_score_p2 + 4'd1;
                            r_serve_dir <= 1'b0;
                            if (r_score_p2 + 4'd1 == 4'(WIN_SCORE)) begin
                                r_state     <= StGameOver;
                                r_game_over <= 1'b1;
                            end
                        end else if (i_ball_out_right && !i_ball_out_left) begin
                            r_score_p1  <= r_score_p1 + 4'd1;
                            r_serve_dir <= 1'b1;
                            if (r_score_p1 + 4'd1 == 4'(WIN_SCORE)) begin
                                r_state     <= StGameOver;
                                r_game_over <= 1'b1;
                            end
                        end
                    end else if (i_frame_start) begin
                        r_move_stb <= 1'b1;
                        r_steps    <= w_steps_load - 4'd1;
                        r_gap      <= GapW'(STEP_GAP - 1);
                    end else if (r_steps != 4'd0) begin
                        if (r_gap == '0) begin
                            r_move_stb <= 1'b1;
                            r_steps    <= r_steps - 4'd1;
                            r_gap      <= GapW'(STEP_GAP - 1);
                        end else begin
                            r_gap <= r_gap - 1'b1;
                        end
                    end
                end
                StPointPause: if (i_frame_start) begin
                    if (r_pause == 8'(PAUSE_FRAMES - 1)) begin
                        r_state <= StServeWait;
                        r_pause <= 8'd0;
                    end else begin
                        r_pause <= r_pause + 8'd1;
                    end
                end
                StGameOver: if (r_press) begin
                    r_state         <= StServeWait;
                    r_score_p1      <= 4'd0;
                    r_score_p2      <= 4'd0;
                    r_ball_recenter <= 1'b1;
                    r_game_over     <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_move_stb      = r_move_stb;
    assign o_ball_recenter = r_ball_recenter;
    assign o_serve_dir     = r_serve_dir;
    assign o_score_p1      = r_score_p1;
    assign o_score_p2      = r_score_p2;
    assign o_game_over     = r_game_over;
    assign o_state         = r_state;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9, score at which a game ends (1..15).
REQ-002 Parameter STEPS_BASE, default 4, movement strobes issued per frame at speed level 0 (1..8).
REQ-003 Parameter STEP_GAP, default 256, clk cycles between consecutive movement strobes within a frame (>=2).
REQ-004 Parameter PAUSE_FRAMES, default 60, frames spent in POINT_PAUSE (1..255).
REQ-005 clk  input  1  pixel clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-008 key_serve_n  input  1  asynchronous serve button, active-low.
REQ-009 ball_out_left / ball_out_right  input  1 each  one-cycle pulses from ball datapath when ball passes left/right edge.
REQ-010 paddle_hit  input  1  one-cycle pulse on any ball/paddle collision.
REQ-011 move_stb  output  1  one-cycle pulse: ball and paddle datapath advance one step.
REQ-012 ball_recenter  output  1  one-cycle pulse: datapath reloads ball to screen centre.
REQ-013 serve_dir  output  1  initial ball horizontal direction, 1 = right.
REQ-014 score_p1 / score_p2  output  4 each  player scores, binary.
REQ-015 game_over  output  1  high while in GAME_OVER.
REQ-016 state_o  output  3  current FSM state encoding (IDLE=0, SERVE_WAIT=1, PLAY=2, POINT_PAUSE=3, GAME_OVER=4).

Function
REQ-017 key_serve_n SHALL pass a 2-flop synchroniser; a serve press is the registered 1->0 transition of the synchronised signal, 3 cycles after pin change.
REQ-018 FSM SHALL be: IDLE -press-> SERVE_WAIT (pulse ball_recenter); SERVE_WAIT -press-> PLAY; PLAY -point-> POINT_PAUSE or GAME_OVER; POINT_PAUSE -PAUSE_FRAMES frame_start pulses-> SERVE_WAIT; GAME_OVER -press-> SERVE_WAIT with both scores cleared and ball_recenter pulsed.
REQ-019 In PLAY, ball_out_left SHALL increment score_p2 and set serve_dir=0; ball_out_right SHALL increment score_p1 and set serve_dir=1; both in the same cycle SHALL award no point but still leave PLAY to POINT_PAUSE.
REQ-020 Any point exit from PLAY SHALL pulse ball_recenter the following cycle; if the incremented score equals WIN_SCORE the FSM SHALL enter GAME_OVER, else POINT_PAUSE; scores never exceed WIN_SCORE.
REQ-021 ball_out_*, paddle_hit and presses SHALL be ignored in states where no transition uses them.
REQ-022 Step scheduler: in PLAY each frame_start SHALL load steps = STEPS_BASE + speed_level and restart the gap counter; first move_stb 1 cycle after frame_start, then one every STEP_GAP cycles until steps issued.
REQ-023 frame_start arriving with steps pending SHALL discard the remainder and reload; move_stb SHALL never be asserted outside PLAY and SHALL stop the cycle PLAY is exited.
REQ-024 frame_start coincident with a point SHALL be treated as a point only (no strobe).

Reset
REQ-025 On reset: state IDLE, scores 0, serve_dir 1, move_stb/ball_recenter/game_over 0, step and pause counters 0, speed_level 0, synchroniser flops 1.
REQ-026 Reset asserted mid-frame or mid-pause SHALL abort all pending strobes in the same edge.

Configuration
REQ-027 Macro PONG_SPEED_RAMP_EN defined: speed_level (2 bits) SHALL increment, saturating at 3, after every 4 paddle_hit pulses in PLAY; hit counter and speed_level clear on every point.
REQ-028 Without PONG_SPEED_RAMP_EN: speed_level constant 0, paddle_hit unused, steps per frame always STEPS_BASE.

Verification
REQ-029 Reset, press serve twice -> IDLE->SERVE_WAIT->PLAY, one ball_recenter pulse, state_o=2.
REQ-030 PLAY, frame_start, STEP_GAP=256 -> 4 move_stb at cycles +1,+257,+513,+769 after frame_start; second frame_start at +600 -> count restarts, total 3+4 strobes.
REQ-031 PLAY, ball_out_right x9 with pauses -> score_p1=9, game_over=1, state_o=4; press -> scores 0, SERVE_WAIT.
REQ-032 ball_out_left and ball_out_right same cycle -> scores unchanged, ball_recenter pulse, POINT_PAUSE; exits after exactly 60 frame_start pulses.
REQ-033 PONG_SPEED_RAMP_EN defined, 8 paddle_hit pulses -> next frame yields 6 move_stb; after a point -> 4; macro undefined -> always 4.
REQ-034 Reset asserted between two strobes -> no further move_stb, all outputs at REQ-025 values next cycle.
